// File: rtl/particle_broadcast_ctrl.sv
// Sequences one cell's particles out of cell memory: waits for the count, issues reads for
// IDs 1..N under pause back-pressure, tags returned words with their ID, then pulses done.
module particle_broadcast_ctrl #(
  parameter int PARTICLE_ID_WIDTH = 7,
  parameter int RD_LATENCY        = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         particle_num_valid,
  input  logic [PARTICLE_ID_WIDTH-1:0] particle_num,
  input  logic                         pause,
  output logic                         rd_en,
  output logic [PARTICLE_ID_WIDTH-1:0] rd_addr,
  output logic                         particle_valid_out,
  output logic [PARTICLE_ID_WIDTH-1:0] particle_id_out,
  output logic                         busy,
  output logic                         broadcast_done
);

  localparam int W   = PARTICLE_ID_WIDTH;
  localparam int DCW = (RD_LATENCY < 2) ? 1 : $clog2(RD_LATENCY + 1);
  localparam logic [W-1:0]   ONE       = W'(1);
  localparam logic [DCW-1:0] DRAIN_END = DCW'(RD_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_NUM,
    S_BROADCAST,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_num;
  logic [W-1:0]   r_id;
  logic [DCW-1:0] r_drain_cnt;
  logic           r_rd_en;
  logic [W-1:0]   r_rd_addr;
  logic           r_busy;
  logic           r_done;

  logic           r_vld_pipe [RD_LATENCY];
  logic [W-1:0]   r_id_pipe  [RD_LATENCY];
  logic [W-1:0]   w_issue_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_num       <= '0;
      r_id        <= '0;
      r_drain_cnt <= '0;
      r_rd_en     <= 1'b0;
      r_rd_addr   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_done    <= 1'b0;
      r_busy    <= (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_WAIT_NUM;
        end
        S_WAIT_NUM: begin
          if (particle_num_valid) begin
            r_num   <= particle_num;
            r_id    <= ONE;
            r_state <= (particle_num == '0) ? S_DONE : S_BROADCAST;
          end
        end
        S_BROADCAST: begin
          if (!pause) begin
            r_rd_en   <= 1'b1;
            r_rd_addr <= r_id - ONE;
            // Equality stop and no increment on the last issue: id never wraps at 2^W-1.
            if (r_id == r_num) begin
              r_state     <= S_DRAIN;
              r_drain_cnt <= '0;
            end else begin
              r_id <= r_id + ONE;
            end
          end
        end
        S_DRAIN: begin
          // Covers the memory latency plus the output register so done trails the last word.
          if (r_drain_cnt == DRAIN_END) r_state <= S_DONE;
          else                          r_drain_cnt <= r_drain_cnt + DCW'(1);
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_issue_id = r_rd_en ? (r_rd_addr + ONE) : '0;

  generate
    for (genvar gi = 0; gi < RD_LATENCY; gi++) begin : g_dly
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) begin
            r_vld_pipe[gi] <= 1'b0;
            r_id_pipe[gi]  <= '0;
          end else begin
            r_vld_pipe[gi] <= r_rd_en;
            r_id_pipe[gi]  <= w_issue_id;
          end
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (rst) begin
            r_vld_pipe[gi] <= 1'b0;
            r_id_pipe[gi]  <= '0;
          end else begin
            r_vld_pipe[gi] <= r_vld_pipe[gi-1];
            r_id_pipe[gi]  <= r_id_pipe[gi-1];
          end
        end
      end
    end
  endgenerate

  assign rd_en              = r_rd_en;
  assign rd_addr            = r_rd_addr;
  assign particle_valid_out = r_vld_pipe[RD_LATENCY-1];
  assign particle_id_out    = r_id_pipe[RD_LATENCY-1];
  assign busy               = r_busy;
  assign broadcast_done     = r_done;

endmodule

// File: tb/tb_particle_broadcast_ctrl.sv
// Directed bench for particle_broadcast_ctrl: a per-cycle vector table for a plain N=5 cell
// plus sequences for empty cell, late count, pause, full-size cell and mid-run reset.
module tb_particle_broadcast_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       nv;
  logic [6:0] num;
  logic       pause;
  logic       rd_en;
  logic [6:0] rd_addr;
  logic       vout;
  logic [6:0] id_out;
  logic       busy;
  logic       done;

  int n_vec  = 0;
  int n_fail = 0;

  particle_broadcast_ctrl #(.PARTICLE_ID_WIDTH(7), .RD_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .start(start), .particle_num_valid(nv), .particle_num(num),
    .pause(pause), .rd_en(rd_en), .rd_addr(rd_addr), .particle_valid_out(vout),
    .particle_id_out(id_out), .busy(busy), .broadcast_done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       e_rd;
    logic [6:0] e_addr;
    logic       e_v;
    logic [6:0] e_id;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(input logic s, input logic r, input int a, input logic v,
                              input int i, input logic b, input logic d);
    vec_t t;
    t.start = s; t.e_rd = r; t.e_addr = a[6:0]; t.e_v = v; t.e_id = i[6:0];
    t.e_busy = b; t.e_done = d;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {14'd0, rd_en, rd_addr, vout, id_out, busy, done};
  endfunction

  // Start at edge 0; count valid from edge nv_edge; pause present at edges p_lo..p_hi.
  task automatic run_cell(input string tag, input int n, input int nv_edge, input int p_lo,
                          input int p_hi, input int exp_first, input int exp_done);
    int reads, vals, dones, first_rd, done_edge, last_v, exp_addr, exp_id;
    reads = 0; vals = 0; dones = 0; first_rd = -1; done_edge = -1; last_v = -1;
    exp_addr = 0; exp_id = 1;
    num   = n[6:0];
    nv    = (nv_edge <= 0);
    start = 1'b1;
    pause = (p_lo <= 0 && 0 <= p_hi);
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (k >= p_lo && k <= p_hi) chk({tag, "_pause_blocks"}, rd_en, 0);
      if (rd_en) begin
        reads++;
        if (first_rd < 0) first_rd = k;
        chk({tag, "_rd_addr"}, rd_addr, exp_addr);
        exp_addr++;
      end
      if (vout) begin
        vals++;
        last_v = k;
        chk({tag, "_id_out"}, id_out, exp_id);
        exp_id++;
      end else if (id_out != 0) begin
        chk({tag, "_id_zero_when_idle"}, id_out, 0);
      end
      if (done) begin
        dones++;
        done_edge = k;
      end
      start = 1'b0;
      nv    = (k + 1 >= nv_edge);
      pause = (k + 1 >= p_lo && k + 1 <= p_hi);
      if (dones > 0 && k >= done_edge + 3) break;
    end
    pause = 1'b0;
    chk({tag, "_reads"}, reads, n);
    chk({tag, "_valids"}, vals, n);
    chk({tag, "_done_pulses"}, dones, 1);
    chk({tag, "_done_edge"}, done_edge, exp_done);
    chk({tag, "_first_rd"}, first_rd, exp_first);
    chk({tag, "_busy_after"}, busy, 0);
    if (n > 0) chk({tag, "_last_valid_before_done"}, (last_v < done_edge), 1);
    $display("cell %s N=%0d: reads=%0d valids=%0d done@%0d", tag, n, reads, vals, done_edge);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; nv = 1'b0; num = '0; pause = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), 0);
    $display("reset: outputs=0x%0h", outs());

    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 1, 0);
    tbl[2]  = mk(0, 1, 0, 0, 0, 1, 0);
    tbl[3]  = mk(0, 1, 1, 0, 0, 1, 0);
    tbl[4]  = mk(0, 1, 2, 1, 1, 1, 0);
    tbl[5]  = mk(0, 1, 3, 1, 2, 1, 0);
    tbl[6]  = mk(0, 1, 4, 1, 3, 1, 0);
    tbl[7]  = mk(0, 0, 0, 1, 4, 1, 0);
    tbl[8]  = mk(0, 0, 0, 1, 5, 1, 0);
    tbl[9]  = mk(0, 0, 0, 0, 0, 1, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 1, 1);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0);

    rst = 1'b0; nv = 1'b1; num = 7'd5;
    for (int k = 0; k < 12; k++) begin
      start = tbl[k].start;
      @(posedge clk); #1;
      chk($sformatf("tbl_n5_edge%0d", k), outs(),
          {14'd0, tbl[k].e_rd, tbl[k].e_addr, tbl[k].e_v, tbl[k].e_id,
           tbl[k].e_busy, tbl[k].e_done});
      $display("edge %0d: rd=%0b addr=%0d v=%0b id=%0d busy=%0b done=%0b",
               k, rd_en, rd_addr, vout, id_out, busy, done);
    end
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    run_cell("n0", 0, 0, -1, -1, -1, 2);
    run_cell("n4_late", 4, 6, -1, -1, 7, 14);
    run_cell("n6_pause", 6, 0, 4, 6, 2, 14);
    run_cell("n127", 127, 0, -1, -1, 2, 132);

    // Mid-run reset during an N=10 cell, with a stray start that must be ignored.
    num = 7'd10; nv = 1'b1; start = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (k >= 2) chk($sformatf("rst_seq_addr_edge%0d", k), {rd_en, rd_addr}, {1'b1, 7'(k - 2)});
      start = (k + 1 == 3);
      rst   = (k + 1 == 5);
    end
    @(posedge clk); #1;
    chk("rst_mid_outputs", outs(), 0);
    $display("mid-run reset: outputs=0x%0h", outs());
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst_quiet%0d", k), {rd_en, vout, busy, done}, 0);
    end
    run_cell("fresh_n3", 3, 0, -1, -1, 2, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
